// File: rtl/bp_mc_bridge_pkg.sv
// Shared definitions for the BP<->manycore bridge request scheduler:
// fence FSM states and reg_id pool sizing.
package bp_mc_bridge_pkg;

  localparam int bsg_manycore_reg_id_width_gp = 5;
  localparam int num_reg_ids_gp = 2 ** bsg_manycore_reg_id_width_gp;

  typedef enum logic [1:0] {
    e_fence_idle,
    e_fence_drain,
    e_fence_done
  } bp_mc_fence_state_e;

endpackage

// File: rtl/bp_mc_reg_id_pool.sv
// reg_id free pool: busy bitmap, lowest-free encode, owner table,
// two release ports and sticky detection of bad releases.
module bp_mc_reg_id_pool
  import bp_mc_bridge_pkg::*;
#(
  parameter int owner_width_p = 1,
  localparam int id_width_lp = bsg_manycore_reg_id_width_gp
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     alloc_v_i,
  input  logic [owner_width_p-1:0] alloc_owner_i,
  output logic                     free_v_o,
  output logic [id_width_lp-1:0]   free_id_o,
  input  logic                     release_a_v_i,
  input  logic [id_width_lp-1:0]   release_a_id_i,
  input  logic                     release_b_v_i,
  input  logic [id_width_lp-1:0]   release_b_id_i,
  input  logic [id_width_lp-1:0]   lookup_id_i,
  output logic [owner_width_p-1:0] lookup_owner_o,
  output logic [1:0]               release_count_o,
  output logic                     error_o
);

  logic [num_reg_ids_gp-1:0] busy_r, busy_n;
  logic [owner_width_p-1:0]  owner_r [num_reg_ids_gp];
  logic                      rel_a_ok, rel_b_ok, same_id, bad_release, error_r;

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    free_v_o  = 1'b0;
    free_id_o = '0;
    for (int i = num_reg_ids_gp - 1; i >= 0; i--) begin
      if (!busy_r[i]) begin
        free_v_o  = 1'b1;
        free_id_o = id_width_lp'(i);
      end
    end
  end

  // Only releases of busy ids free anything; a duplicate id on port b is dropped.
  assign same_id     = release_a_v_i & release_b_v_i & (release_a_id_i == release_b_id_i);
  assign rel_a_ok    = release_a_v_i & busy_r[release_a_id_i];
  assign rel_b_ok    = release_b_v_i & busy_r[release_b_id_i] & ~same_id;
  assign bad_release = (release_a_v_i & ~busy_r[release_a_id_i])
                     | (release_b_v_i & ~busy_r[release_b_id_i])
                     | same_id;

  assign release_count_o = {1'b0, rel_a_ok} + {1'b0, rel_b_ok};
  assign lookup_owner_o  = owner_r[lookup_id_i];
  assign error_o         = error_r;

  always_comb begin
    busy_n = busy_r;
    if (rel_a_ok) busy_n[release_a_id_i] = 1'b0;
    if (rel_b_ok) busy_n[release_b_id_i] = 1'b0;
    if (alloc_v_i) busy_n[free_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_r  <= '0;
      error_r <= 1'b0;
      for (int i = 0; i < num_reg_ids_gp; i++) owner_r[i] <= '0;
    end else begin
      busy_r <= busy_n;
      if (bad_release) error_r <= 1'b1;
      if (alloc_v_i) owner_r[free_id_o] <= alloc_owner_i;
    end
  end

endmodule

// File: rtl/bp_mc_bridge_req_scheduler.sv
// Round-robin scheduler of requester packets onto the manycore endpoint link,
// with reg_id allocation, credit limiting, response routing and a drain fence.
module bp_mc_bridge_req_scheduler
  import bp_mc_bridge_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int mc_addr_width_p   = 10,
  parameter int mc_data_width_p   = 32,
  parameter int mc_x_cord_width_p = 4,
  parameter int mc_y_cord_width_p = 4,
  parameter int max_out_credits_p = 16,
  localparam int owner_width_lp   = $clog2(num_req_p),
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
  localparam int reg_id_width_lp  = bsg_manycore_reg_id_width_gp,
  localparam int packet_width_lp  = mc_addr_width_p + mc_data_width_p + mc_x_cord_width_p
                                  + mc_y_cord_width_p + reg_id_width_lp
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p-1:0]                      req_v_i,
  input  logic [num_req_p-1:0][packet_width_lp-1:0] req_packet_i,
  output logic [num_req_p-1:0]                      req_yumi_o,
  output logic                                      out_v_o,
  output logic [packet_width_lp-1:0]                out_packet_o,
  input  logic                                      out_ready_i,
  input  logic                                      returned_v_i,
  input  logic [reg_id_width_lp-1:0]                returned_reg_id_i,
  input  logic                                      returned_yumi_i,
  input  logic                                      returned_credit_v_i,
  input  logic [reg_id_width_lp-1:0]                returned_credit_reg_id_i,
  output logic [owner_width_lp-1:0]                 returned_owner_o,
  input  logic                                      fence_v_i,
  output logic                                      fence_ready_o,
  output logic                                      fence_done_o,
  output logic [credit_width_lp-1:0]                credits_used_o,
  output logic                                      error_o
);

  logic [owner_width_lp-1:0]  rr_r, winner, idx_w;
  logic                       found, grant_ok, accept, free_v;
  logic [reg_id_width_lp-1:0] free_id;
  logic [1:0]                 release_count;
  logic [credit_width_lp-1:0] credits_r;
  bp_mc_fence_state_e         state_r, state_n;
  logic                       unused_reg_id_fields;
  int                         idx;

  // The reg_id field of incoming packets is overwritten, so it is never read.
  always_comb begin
    unused_reg_id_fields = 1'b0;
    for (int k = 0; k < num_req_p; k++)
      unused_reg_id_fields = unused_reg_id_fields ^ (^req_packet_i[k][reg_id_width_lp-1:0]);
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      idx_w = owner_width_lp'(idx);
      if (!found && req_v_i[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign grant_ok     = (credits_r < credit_width_lp'(max_out_credits_p)) & free_v
                      & (state_r == e_fence_idle);
  assign out_v_o      = found & grant_ok;
  assign accept       = out_v_o & out_ready_i;
  assign req_yumi_o   = num_req_p'(accept) << winner;
  assign out_packet_o = {req_packet_i[winner][packet_width_lp-1:reg_id_width_lp], free_id};
  assign credits_used_o = credits_r;

  bp_mc_reg_id_pool #(.owner_width_p(owner_width_lp)) pool (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .alloc_v_i      (accept),
    .alloc_owner_i  (winner),
    .free_v_o       (free_v),
    .free_id_o      (free_id),
    .release_a_v_i  (returned_v_i & returned_yumi_i),
    .release_a_id_i (returned_reg_id_i),
    .release_b_v_i  (returned_credit_v_i),
    .release_b_id_i (returned_credit_reg_id_i),
    .lookup_id_i    (returned_reg_id_i),
    .lookup_owner_o (returned_owner_o),
    .release_count_o(release_count),
    .error_o        (error_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_r      <= '0;
      credits_r <= '0;
      state_r   <= e_fence_idle;
    end else begin
      state_r   <= state_n;
      credits_r <= credits_r + credit_width_lp'(accept) - credit_width_lp'(release_count);
      if (accept)
        rr_r <= (winner == owner_width_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    state_n       = state_r;
    fence_ready_o = 1'b0;
    fence_done_o  = 1'b0;
    unique case (state_r)
      e_fence_idle: begin
        fence_ready_o = 1'b1;
        if (fence_v_i) state_n = e_fence_drain;
      end
      e_fence_drain: begin
        if (credits_r == '0) state_n = e_fence_done;
      end
      e_fence_done: begin
        fence_done_o = 1'b1;
        state_n      = e_fence_idle;
      end
      default: state_n = e_fence_idle;
    endcase
  end

endmodule

// File: tb/tb_bp_mc_bridge_req_scheduler.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// against a behavioural model of the scheduler built from arrays and counters.
module tb_bp_mc_bridge_req_scheduler;
  import bp_mc_bridge_pkg::*;

  localparam int NR   = 2;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int MAXC = 4;
  localparam int RW   = bsg_manycore_reg_id_width_gp;
  localparam int NID  = num_reg_ids_gp;
  localparam int PW   = AW + DW + XW + YW + RW;
  localparam int OW   = $clog2(NR);
  localparam int CW   = $clog2(MAXC + 1);

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic [NR-1:0]          req_v;
  logic [NR-1:0][PW-1:0]  req_packet;
  logic [NR-1:0]          req_yumi;
  logic                   out_v;
  logic [PW-1:0]          out_packet;
  logic                   out_ready;
  logic                   returned_v;
  logic [RW-1:0]          returned_reg_id;
  logic                   returned_yumi;
  logic                   returned_credit_v;
  logic [RW-1:0]          returned_credit_reg_id;
  logic [OW-1:0]          returned_owner;
  logic                   fence_v;
  logic                   fence_ready;
  logic                   fence_done;
  logic [CW-1:0]          credits_used;
  logic                   error;

  always #5 clk_i = ~clk_i;

  bp_mc_bridge_req_scheduler #(
    .num_req_p(NR), .mc_addr_width_p(AW), .mc_data_width_p(DW),
    .mc_x_cord_width_p(XW), .mc_y_cord_width_p(YW), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v), .req_packet_i(req_packet), .req_yumi_o(req_yumi),
    .out_v_o(out_v), .out_packet_o(out_packet), .out_ready_i(out_ready),
    .returned_v_i(returned_v), .returned_reg_id_i(returned_reg_id),
    .returned_yumi_i(returned_yumi),
    .returned_credit_v_i(returned_credit_v),
    .returned_credit_reg_id_i(returned_credit_reg_id),
    .returned_owner_o(returned_owner),
    .fence_v_i(fence_v), .fence_ready_o(fence_ready), .fence_done_o(fence_done),
    .credits_used_o(credits_used), .error_o(error)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model state: which ids are out, who owns them, how many are out.
  bit m_busy [NID];
  int m_owner [NID];
  int m_count, m_rr, m_phase;
  bit m_err;
  bit e_v;
  int e_win, e_id;
  int busy_list[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NID; i++) begin
      m_busy[i]  = 1'b0;
      m_owner[i] = 0;
    end
    m_count = 0;
    m_rr    = 0;
    m_phase = 0;
    m_err   = 1'b0;
  endtask

  task automatic compute_expect();
    e_id = -1;
    for (int i = 0; i < NID; i++)
      if (!m_busy[i] && e_id < 0) e_id = i;
    e_win = -1;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_rr + i) % NR;
      if (req_v[k] && e_win < 0) e_win = k;
    end
    e_v = (e_win >= 0) && (m_count < MAXC) && (e_id >= 0) && (m_phase == 0);
  endtask

  task automatic check_output();
    logic [PW-1:0] p;
    compute_expect();
    check("out_v", 64'(out_v), 64'(e_v));
    check("req_yumi", 64'(req_yumi), (e_v && out_ready) ? (64'd1 << e_win) : 64'd0);
    if (e_v) begin
      p = req_packet[e_win];
      p[RW-1:0] = RW'(e_id);
      check("out_packet", 64'(out_packet), 64'(p));
    end
    check("credits_used", 64'(credits_used), 64'(m_count));
    check("fence_ready", 64'(fence_ready), 64'(m_phase == 0));
    check("fence_done", 64'(fence_done), 64'(m_phase == 2));
    check("error", 64'(error), 64'(m_err));
    if (returned_v)
      check("returned_owner", 64'(returned_owner), 64'(m_owner[returned_reg_id]));
  endtask

  task automatic update_model();
    bit acc, rel_a, rel_b, a_ok, b_ok, same;
    int ida, idb, pre_count;
    compute_expect();
    acc   = e_v && out_ready;
    rel_a = returned_v && returned_yumi;
    rel_b = returned_credit_v;
    ida   = int'(returned_reg_id);
    idb   = int'(returned_credit_reg_id);
    same  = rel_a && rel_b && (ida == idb);
    a_ok  = rel_a && m_busy[ida];
    b_ok  = rel_b && m_busy[idb] && !same;
    if ((rel_a && !m_busy[ida]) || (rel_b && !m_busy[idb]) || same) m_err = 1'b1;
    pre_count = m_count;
    if (a_ok) m_busy[ida] = 1'b0;
    if (b_ok) m_busy[idb] = 1'b0;
    if (acc) begin
      m_busy[e_id]  = 1'b1;
      m_owner[e_id] = e_win;
      m_rr = (e_win + 1) % NR;
    end
    m_count = m_count + int'(acc) - int'(a_ok) - int'(b_ok);
    case (m_phase)
      0: if (fence_v) m_phase = 1;
      1: if (pre_count == 0) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  task automatic apply_stimulus();
    #1;
    check_output();
    @(posedge clk_i);
    update_model();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    req_v = '0; out_ready = 1'b0; returned_v = 1'b0; returned_reg_id = '0;
    returned_yumi = 1'b0; returned_credit_v = 1'b0; returned_credit_reg_id = '0;
    fence_v = 1'b0;
  endtask

  task automatic randomize_packets();
    for (int k = 0; k < NR; k++) req_packet[k] = PW'({$urandom(), $urandom()});
  endtask

  initial begin
    reset_i = 1'b1;
    clear_inputs();
    randomize_packets();
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Reset state.
    #1;
    check("rst_credits", 64'(credits_used), 64'd0);
    check("rst_fence_ready", 64'(fence_ready), 64'd1);
    apply_stimulus();

    // Alternating grants: winners 0,1,0,1 with ids 0..3.
    req_v = 2'b11; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      randomize_packets();
      #1;
      check("alt_yumi", 64'(req_yumi), (c % 2 == 0) ? 64'd1 : 64'd2);
      check("alt_reg_id", 64'(out_packet[RW-1:0]), 64'(c));
      apply_stimulus();
    end
    #1;
    check("full_credits", 64'(credits_used), 64'd4);
    check("full_out_v", 64'(out_v), 64'd0);

    // Credit-only release of id 2 becomes grantable only next cycle.
    returned_credit_v = 1'b1; returned_credit_reg_id = RW'(2);
    #1;
    check("rel_no_bypass", 64'(out_v), 64'd0);
    apply_stimulus();
    returned_credit_v = 1'b0;
    #1;
    check("reuse_out_v", 64'(out_v), 64'd1);
    check("reuse_reg_id", 64'(out_packet[RW-1:0]), 64'd2);
    apply_stimulus();

    // Owner routing without and then with consumption.
    req_v = '0;
    returned_v = 1'b1; returned_reg_id = RW'(1); returned_yumi = 1'b0;
    #1;
    check("owner_id1", 64'(returned_owner), 64'd1);
    apply_stimulus();
    returned_yumi = 1'b1;
    #1;
    check("owner_hold_count", 64'(credits_used), 64'd4);
    apply_stimulus();
    returned_v = 1'b0; returned_yumi = 1'b0;
    #1;
    check("owner_dec_count", 64'(credits_used), 64'd3);
    apply_stimulus();

    // Fence drain with ids 0,2,3 outstanding.
    fence_v = 1'b1;
    apply_stimulus();
    fence_v = 1'b0; req_v = 2'b11;
    returned_credit_v = 1'b1;
    returned_credit_reg_id = RW'(0);
    #1;
    check("drain_block", 64'(out_v), 64'd0);
    apply_stimulus();
    returned_credit_reg_id = RW'(2);
    apply_stimulus();
    returned_credit_reg_id = RW'(3);
    apply_stimulus();
    returned_credit_v = 1'b0;
    #1;
    check("drain_zero", 64'(credits_used), 64'd0);
    check("drain_not_done", 64'(fence_done), 64'd0);
    apply_stimulus();
    #1;
    check("fence_done", 64'(fence_done), 64'd1);
    check("done_block", 64'(out_v), 64'd0);
    apply_stimulus();
    #1;
    check("resume_out_v", 64'(out_v), 64'd1);
    check("resume_yumi", 64'(req_yumi), 64'd2);
    apply_stimulus();

    // Dual release plus grant: ids 0,1,2 out, grant takes id 3.
    apply_stimulus();
    apply_stimulus();
    returned_v = 1'b1; returned_yumi = 1'b1; returned_reg_id = RW'(0);
    returned_credit_v = 1'b1; returned_credit_reg_id = RW'(2);
    #1;
    check("dual_reg_id", 64'(out_packet[RW-1:0]), 64'd3);
    apply_stimulus();
    clear_inputs();
    #1;
    check("dual_count", 64'(credits_used), 64'd2);
    apply_stimulus();

    // Error on free id, then reset in the middle of a drain.
    returned_credit_v = 1'b1; returned_credit_reg_id = RW'(5);
    apply_stimulus();
    returned_credit_v = 1'b0;
    #1;
    check("error_set", 64'(error), 64'd1);
    apply_stimulus();
    #1;
    check("error_hold", 64'(error), 64'd1);
    fence_v = 1'b1;
    apply_stimulus();
    fence_v = 1'b0;
    apply_stimulus();
    reset_i = 1'b1;
    #1;
    check("midrst_credits", 64'(credits_used), 64'd0);
    check("midrst_fence_ready", 64'(fence_ready), 64'd1);
    check("midrst_error", 64'(error), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    apply_stimulus();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      randomize_packets();
      req_v     = NR'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      fence_v   = ($urandom_range(0, 24) == 0);
      busy_list.delete();
      for (int i = 0; i < NID; i++) if (m_busy[i]) busy_list.push_back(i);
      if (busy_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        int j;
        j = int'($urandom_range(0, busy_list.size() - 1));
        returned_v = 1'b1;
        returned_reg_id = RW'(busy_list[j]);
        returned_yumi = $urandom_range(0, 1) == 1;
        if (returned_yumi) busy_list.delete(j);
      end
      if (busy_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        int j;
        j = int'($urandom_range(0, busy_list.size() - 1));
        returned_credit_v = 1'b1;
        returned_credit_reg_id = RW'(busy_list[j]);
      end
      apply_stimulus();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
